// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the I/D memory-port arbiter: FSM state encoding and grant identity.
package mem_port_arbiter_pkg;

  localparam int unsigned WORD_SIZE_DEF = 16;
  localparam int unsigned ADDR_SIZE_DEF = 16;

  // Encodings are fixed so pipeline control and benches can decode the raw state.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_I_BUSY = 2'd1,
    ST_D_BUSY = 2'd2
  } arb_state_e;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and backing-memory handshakes around the arbiter.
// master = arbiter view; slave = pipeline + memory view.
interface mem_port_arbiter_if
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned WORD_SIZE = WORD_SIZE_DEF,
  parameter int unsigned ADDR_SIZE = ADDR_SIZE_DEF
);
  logic                 i_req;
  logic [ADDR_SIZE-1:0] i_addr;
  logic [WORD_SIZE-1:0] i_rdata;
  logic                 i_ready;
  logic                 i_stall;

  logic                 d_req;
  logic                 d_we;
  logic [ADDR_SIZE-1:0] d_addr;
  logic [WORD_SIZE-1:0] d_wdata;
  logic [WORD_SIZE-1:0] d_rdata;
  logic                 d_ready;
  logic                 d_stall;

  logic                 m_read;
  logic                 m_write;
  logic [ADDR_SIZE-1:0] m_addr;
  logic [WORD_SIZE-1:0] m_wdata;
  logic [WORD_SIZE-1:0] m_rdata;
  logic                 m_ack;

  modport master (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata, m_ack,
    output i_rdata, i_ready, i_stall, d_rdata, d_ready, d_stall,
           m_read, m_write, m_addr, m_wdata
  );

  modport slave (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata, m_ack,
    input  i_rdata, i_ready, i_stall, d_rdata, d_ready, d_stall,
           m_read, m_write, m_addr, m_wdata
  );

endinterface

// File: rtl/mem_port_arbiter.sv
// Serializes I-fetch and D-access requests onto one memory port (D priority).
// Define ARB_ROUND_ROBIN_EN to alternate grants when both sides are eligible.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned WORD_SIZE = WORD_SIZE_DEF,
  parameter int unsigned ADDR_SIZE = ADDR_SIZE_DEF
) (
  input  logic               clk,
  input  logic               reset_n,
  mem_port_arbiter_if.master bus
);

  arb_state_e           r_state;
  arb_state_e           w_state_nxt;
  logic                 r_m_read;
  logic                 r_m_write;
  logic [ADDR_SIZE-1:0] r_m_addr;
  logic [WORD_SIZE-1:0] r_m_wdata;
  logic [WORD_SIZE-1:0] r_i_rdata;
  logic [WORD_SIZE-1:0] r_d_rdata;
  logic                 r_i_ready;
  logic                 r_d_ready;
  logic                 r_live;

  logic w_i_elig;
  logic w_d_elig;
  logic w_pick_d;
  logic w_grant_i;
  logic w_grant_d;
  logic w_busy;
  logic w_req_cur;

  // A requester still holding req during its own ready cycle must not be re-granted.
  assign w_i_elig  = bus.i_req & ~r_i_ready;
  assign w_d_elig  = bus.d_req & ~r_d_ready;
  assign w_busy    = (r_state != ST_IDLE);
  assign w_req_cur = (r_state == ST_I_BUSY) ? bus.i_req : bus.d_req;

`ifdef ARB_ROUND_ROBIN_EN
  grant_e r_last_grant;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last_grant <= GRANT_I;
    end else if (w_grant_d) begin
      r_last_grant <= GRANT_D;
    end else if (w_grant_i) begin
      r_last_grant <= GRANT_I;
    end
  end

  assign w_pick_d = (r_last_grant == GRANT_I);
`else
  assign w_pick_d = 1'b1;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_grant_i   = 1'b0;
    w_grant_d   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_d_elig && (!w_i_elig || w_pick_d)) begin
          w_grant_d   = 1'b1;
          w_state_nxt = ST_D_BUSY;
        end else if (w_i_elig) begin
          w_grant_i   = 1'b1;
          w_state_nxt = ST_I_BUSY;
        end
      end
      ST_I_BUSY, ST_D_BUSY: begin
        if (bus.m_ack) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_m_read  <= 1'b0;
      r_m_write <= 1'b0;
      r_m_addr  <= '0;
      r_m_wdata <= '0;
      r_i_rdata <= '0;
      r_d_rdata <= '0;
      r_i_ready <= 1'b0;
      r_d_ready <= 1'b0;
      r_live    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_i_ready <= 1'b0;
      r_d_ready <= 1'b0;
      if (w_grant_d) begin
        r_m_read  <= ~bus.d_we;
        r_m_write <= bus.d_we;
        r_m_addr  <= bus.d_addr;
        r_m_wdata <= bus.d_wdata;
        r_live    <= 1'b1;
      end else if (w_grant_i) begin
        r_m_read  <= 1'b1;
        r_m_write <= 1'b0;
        r_m_addr  <= bus.i_addr;
        r_live    <= 1'b1;
      end else if (w_busy) begin
        // Once req drops the transaction is orphaned: memory finishes it, requester hears nothing.
        if (!w_req_cur) begin
          r_live <= 1'b0;
        end
        if (bus.m_ack) begin
          r_m_read  <= 1'b0;
          r_m_write <= 1'b0;
          if (r_live && w_req_cur) begin
            if (r_state == ST_I_BUSY) begin
              r_i_ready <= 1'b1;
              r_i_rdata <= bus.m_rdata;
            end else begin
              r_d_ready <= 1'b1;
              if (r_m_read) begin
                r_d_rdata <= bus.m_rdata;
              end
            end
          end
        end
      end
    end
  end

  assign bus.i_rdata = r_i_rdata;
  assign bus.i_ready = r_i_ready;
  assign bus.i_stall = bus.i_req & ~r_i_ready;
  assign bus.d_rdata = r_d_rdata;
  assign bus.d_ready = r_d_ready;
  assign bus.d_stall = bus.d_req & ~r_d_ready;
  assign bus.m_read  = r_m_read;
  assign bus.m_write = r_m_write;
  assign bus.m_addr  = r_m_addr;
  assign bus.m_wdata = r_m_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a latency-programmable memory responder.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  int          checks = 0;
  int          errors = 0;
  int unsigned mem_lat = 1;
  logic        spurious = 1'b0;
  int          ack_count = 0;

  mem_port_arbiter_if #(.WORD_SIZE(16), .ADDR_SIZE(16)) bus ();

  mem_port_arbiter #(.WORD_SIZE(16), .ADDR_SIZE(16)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    if (a == 16'h0010) return 16'h6A01;
    return a ^ 16'hC3C3;
  endfunction

  // Acks mem_lat cycles after a strobe appears; tolerates strobes withdrawn without ack.
  initial begin : memory_model
    int unsigned cnt;
    cnt = 0;
    bus.m_ack = 1'b0;
    bus.m_rdata = '0;
    forever begin
      @(negedge clk);
      if (bus.m_ack) begin
        bus.m_ack = 1'b0;
        cnt = 0;
      end else if (spurious) begin
        bus.m_ack = 1'b1;
        bus.m_rdata = 16'h1234;
        spurious = 1'b0;
      end else if (bus.m_read || bus.m_write) begin
        cnt++;
        if (cnt >= mem_lat) begin
          bus.m_ack = 1'b1;
          bus.m_rdata = bus.m_read ? mem_word(bus.m_addr) : 16'hDEAD;
          ack_count++;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      checks++;
      if ((bus.m_read & bus.m_write) !== 1'b0) begin
        errors++;
        $display("FAIL strobe_exclusive: m_read=%b m_write=%b, required not both 1", bus.m_read, bus.m_write);
      end
    end
  end

  task automatic wait_ready(input int max, output logic got_i, output logic got_d, output int n);
    got_i = 1'b0;
    got_d = 1'b0;
    n = 0;
    while (!got_i && !got_d && n < max) begin
      @(negedge clk);
      n++;
      got_i = bus.i_ready;
      got_d = bus.d_ready;
    end
  endtask

  task automatic test_reset();
    logic bad;
    bus.i_req = 1'b1; bus.i_addr = 16'h0077;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.m_read, bus.m_write, bus.i_ready, bus.d_ready} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b, required 0000", {bus.m_read, bus.m_write, bus.i_ready, bus.d_ready});
    end
    checks++;
    if ({bus.m_addr, bus.m_wdata, bus.i_rdata, bus.d_rdata} !== 64'h0) begin
      errors++;
      $display("FAIL reset_data: got %h, required 0", {bus.m_addr, bus.m_wdata, bus.i_rdata, bus.d_rdata});
    end
    bus.i_req = 1'b0;
    reset_n = 1'b1;
    bad = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (bus.m_read !== 1'b0 || bus.m_write !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_strobe: strobe seen=%b, required 0", bad);
    end
    spurious = 1'b1;
    bad = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if ({bus.m_read, bus.m_write, bus.i_ready, bus.d_ready} !== 4'b0000) bad = 1'b1;
    end
    checks++;
    if (bad !== 1'b0) begin
      errors++;
      $display("FAIL idle_ack_ignored: activity=%b, required 0", bad);
    end
  endtask

  task automatic test_single_fetch();
    logic got, bad, saw_addr;
    int n;
    @(negedge clk);
    mem_lat = 2;
    bus.i_req = 1'b1;
    bus.i_addr = 16'h0010;
    #1;
    checks++;
    if (bus.i_stall !== 1'b1) begin
      errors++;
      $display("FAIL fetch_stall_start: i_stall=%b, required 1", bus.i_stall);
    end
    n = 0; got = 1'b0; bad = 1'b0; saw_addr = 1'b0;
    while (!got && n < 10) begin
      @(negedge clk);
      n++;
      got = bus.i_ready;
      if (!got && bus.i_stall !== 1'b1) bad = 1'b1;
      if (n == 1 && bus.m_read === 1'b1 && bus.m_addr === 16'h0010) saw_addr = 1'b1;
    end
    checks++;
    if (saw_addr !== 1'b1) begin
      errors++;
      $display("FAIL fetch_m_addr: m_read=%b m_addr=%h, required 1/0010", bus.m_read, bus.m_addr);
    end
    checks++;
    if (got !== 1'b1 || n != 3) begin
      errors++;
      $display("FAIL fetch_latency: ready=%b after %0d cycles, required 1 after 3", got, n);
    end
    checks++;
    if (bus.i_rdata !== 16'h6A01 || bus.i_stall !== 1'b0 || bad !== 1'b0) begin
      errors++;
      $display("FAIL fetch_data: i_rdata=%h stall=%b stall_gap=%b, required 6a01/0/0", bus.i_rdata, bus.i_stall, bad);
    end
    bus.i_req = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.i_ready !== 1'b0 || bus.m_read !== 1'b0 || bus.i_rdata !== 16'h6A01) begin
      errors++;
      $display("FAIL fetch_pulse: i_ready=%b m_read=%b i_rdata=%h, required 0/0/6a01", bus.i_ready, bus.m_read, bus.i_rdata);
    end
  endtask

  task automatic test_conflict();
    @(negedge clk);
    mem_lat = 1;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 16'h0040;
    bus.i_req = 1'b1; bus.i_addr = 16'h0020;
    @(negedge clk);
    checks++;
    if ({bus.m_read, bus.m_write} !== 2'b10 || bus.m_addr !== 16'h0040) begin
      errors++;
      $display("FAIL conflict_d_first: rd/wr=%b addr=%h, required 10/0040", {bus.m_read, bus.m_write}, bus.m_addr);
    end
    checks++;
    if (bus.i_stall !== 1'b1 || bus.d_stall !== 1'b1) begin
      errors++;
      $display("FAIL conflict_stalls: i_stall=%b d_stall=%b, required 1/1", bus.i_stall, bus.d_stall);
    end
    @(negedge clk);
    checks++;
    if (bus.d_ready !== 1'b1 || bus.d_rdata !== 16'hC383 || bus.d_stall !== 1'b0 || bus.i_stall !== 1'b1) begin
      errors++;
      $display("FAIL conflict_d_done: d_ready=%b d_rdata=%h d_stall=%b i_stall=%b, required 1/c383/0/1",
               bus.d_ready, bus.d_rdata, bus.d_stall, bus.i_stall);
    end
    bus.d_req = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.m_read !== 1'b1 || bus.m_addr !== 16'h0020 || bus.d_ready !== 1'b0 || bus.i_stall !== 1'b1) begin
      errors++;
      $display("FAIL b2b_i_grant: m_read=%b m_addr=%h d_ready=%b i_stall=%b, required 1/0020/0/1",
               bus.m_read, bus.m_addr, bus.d_ready, bus.i_stall);
    end
    @(negedge clk);
    checks++;
    if (bus.i_ready !== 1'b1 || bus.i_rdata !== 16'hC3E3) begin
      errors++;
      $display("FAIL conflict_i_done: i_ready=%b i_rdata=%h, required 1/c3e3", bus.i_ready, bus.i_rdata);
    end
    bus.i_req = 1'b0;
  endtask

  task automatic test_store();
    @(negedge clk);
    mem_lat = 1;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 16'h0041; bus.d_wdata = 16'hBEEF;
    @(negedge clk);
    checks++;
    if ({bus.m_read, bus.m_write} !== 2'b01 || bus.m_addr !== 16'h0041 || bus.m_wdata !== 16'hBEEF) begin
      errors++;
      $display("FAIL store_bus: rd/wr=%b addr=%h wdata=%h, required 01/0041/beef",
               {bus.m_read, bus.m_write}, bus.m_addr, bus.m_wdata);
    end
    @(negedge clk);
    checks++;
    if (bus.d_ready !== 1'b1 || bus.d_rdata !== 16'hC383) begin
      errors++;
      $display("FAIL store_done: d_ready=%b d_rdata=%h, required 1/c383", bus.d_ready, bus.d_rdata);
    end
    bus.d_req = 1'b0; bus.d_we = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.d_ready !== 1'b0 || bus.m_write !== 1'b0) begin
      errors++;
      $display("FAIL store_pulse: d_ready=%b m_write=%b, required 0/0", bus.d_ready, bus.m_write);
    end
  endtask

  task automatic test_flush();
    int   a0;
    logic bad;
    @(negedge clk);
    mem_lat = 3;
    a0 = ack_count;
    bus.i_req = 1'b1; bus.i_addr = 16'h0030;
    @(negedge clk);
    checks++;
    if (bus.m_read !== 1'b1 || bus.m_addr !== 16'h0030) begin
      errors++;
      $display("FAIL flush_grant: m_read=%b m_addr=%h, required 1/0030", bus.m_read, bus.m_addr);
    end
    bus.i_req = 1'b0;
    bad = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (bus.i_ready !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad !== 1'b0 || bus.i_rdata !== 16'hC3E3) begin
      errors++;
      $display("FAIL flush_no_ready: ready_seen=%b i_rdata=%h, required 0/c3e3", bad, bus.i_rdata);
    end
    checks++;
    if (bus.m_read !== 1'b0 || ack_count != a0 + 1) begin
      errors++;
      $display("FAIL flush_mem_done: m_read=%b acks=%0d, required 0/%0d", bus.m_read, ack_count, a0 + 1);
    end
  endtask

  task automatic test_reset_mid();
    logic bad;
    @(negedge clk);
    mem_lat = 4;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 16'h0050;
    @(negedge clk);
    checks++;
    if (bus.m_read !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_busy: m_read=%b, required 1", bus.m_read);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (bus.m_read !== 1'b0 || bus.m_write !== 1'b0 || bus.d_rdata !== 16'h0 || bus.i_rdata !== 16'h0) begin
      errors++;
      $display("FAIL rstmid_async: rd=%b wr=%b d_rdata=%h i_rdata=%h, required 0/0/0/0",
               bus.m_read, bus.m_write, bus.d_rdata, bus.i_rdata);
    end
    bus.d_req = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    bad = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if ({bus.d_ready, bus.m_read, bus.m_write} !== 3'b000) bad = 1'b1;
    end
    checks++;
    if (bad !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_quiet: activity=%b, required 0", bad);
    end
  endtask

  task automatic test_alternate();
    logic [3:0] pat;
    int         n, k;
    logic       both;
    @(negedge clk);
    mem_lat = 1;
    bus.i_req = 1'b1; bus.i_addr = 16'h0060;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 16'h0070;
    pat = '0; n = 0; k = 0; both = 1'b0;
    while (k < 4 && n < 40) begin
      @(negedge clk);
      n++;
      if (bus.i_ready && bus.d_ready) both = 1'b1;
      if (bus.d_ready === 1'b1) begin pat = {pat[2:0], 1'b1}; k++; end
      else if (bus.i_ready === 1'b1) begin pat = {pat[2:0], 1'b0}; k++; end
    end
    bus.i_req = 1'b0; bus.d_req = 1'b0;
    checks++;
    if (k != 4 || pat !== 4'b1010 || both !== 1'b0) begin
      errors++;
      $display("FAIL alternate_order: completions=%0d pattern=%b both=%b, required 4/1010/0", k, pat, both);
    end
    checks++;
    if (bus.d_rdata !== 16'hC3B3 || bus.i_rdata !== 16'hC3A3) begin
      errors++;
      $display("FAIL alternate_data: d_rdata=%h i_rdata=%h, required c3b3/c3a3", bus.d_rdata, bus.i_rdata);
    end
  endtask

  task automatic test_priority();
    logic gi, gd, exp_d_first;
    int   n;
    @(negedge clk);
    mem_lat = 1;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 16'h0070;
    wait_ready(10, gi, gd, n);
    bus.d_req = 1'b0;
    checks++;
    if (gd !== 1'b1) begin
      errors++;
      $display("FAIL prio_d_alone: d_ready=%b after %0d cycles, required 1", gd, n);
    end
    @(negedge clk);
    bus.i_req = 1'b1; bus.i_addr = 16'h0060;
    bus.d_req = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
    exp_d_first = 1'b0;
`else
    exp_d_first = 1'b1;
`endif
    wait_ready(10, gi, gd, n);
    checks++;
    if (gd !== exp_d_first || gi !== ~exp_d_first) begin
      errors++;
      $display("FAIL prio_first: d_ready=%b i_ready=%b, required d=%b i=%b", gd, gi, exp_d_first, ~exp_d_first);
    end
    if (gd) bus.d_req = 1'b0;
    if (gi) bus.i_req = 1'b0;
    wait_ready(10, gi, gd, n);
    bus.i_req = 1'b0; bus.d_req = 1'b0;
    checks++;
    if (gd !== ~exp_d_first || gi !== exp_d_first) begin
      errors++;
      $display("FAIL prio_second: d_ready=%b i_ready=%b, required d=%b i=%b", gd, gi, ~exp_d_first, exp_d_first);
    end
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_conflict();
    test_store();
    test_flush();
    test_reset_mid();
    test_alternate();
    test_priority();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single backing-memory port between instruction fetch (I side) and the MEM-stage data access (D side) of the 5-stage pipeline.
- Serializes requests through a small FSM.
- Returns per-requester ready pulses and read data.
- Generates the i_stall/d_stall signals the pipeline control uses alongside load-use hazard stalls.

Parameters:
WORD_SIZE, 16, data width; matches the `WORD_SIZE` define in opcodes.v.
ADDR_SIZE, 16, address width.

Ports:
clk  input  1  clock; all state updates on rising edge
reset_n  input  1  asynchronous, active-low reset
i_req  input  1  fetch request; held high until i_ready is seen
i_addr  input  ADDR_SIZE  fetch address; stable while i_req is high
i_rdata  output  WORD_SIZE  fetched instruction; registered, held until next I completion
i_ready  output  1  one-cycle pulse when the fetch completes
i_stall  output  1  i_req & ~i_ready (combinational)
d_req  input  1  data request; held high until d_ready is seen
d_we  input  1  1 = write, 0 = read
d_addr  input  ADDR_SIZE  data address
d_wdata  input  WORD_SIZE  write data
d_rdata  output  WORD_SIZE  load data; registered, held
d_ready  output  1  one-cycle completion pulse
d_stall  output  1  d_req & ~d_ready (combinational)
m_read  output  1  memory read strobe; held until m_ack
m_write  output  1  memory write strobe; held until m_ack
m_addr  output  ADDR_SIZE  latched address
m_wdata  output  WORD_SIZE  latched write data
m_rdata  input  WORD_SIZE  memory read data; valid in the m_ack cycle
m_ack  input  1  memory completion, one-cycle pulse

Behaviour:
- Reset (async, reset_n=0): state=IDLE; all outputs 0 (i_rdata, d_rdata, m_addr, m_wdata = 0); last_grant=I.
- States: IDLE, I_BUSY, D_BUSY.
- Eligibility in IDLE: a side is eligible if req=1 and its ready=0 this cycle.
  - This masks the requester that is still asserting req in its ready cycle.
- IDLE -> D_BUSY when D is eligible:
  - D has fixed priority, because it is the older instruction.
  - Latch d_we, d_addr, d_wdata.
  - Assert m_write=d_we or m_read=~d_we from the next cycle.
- IDLE -> I_BUSY when only I is eligible:
  - Latch i_addr.
  - m_read=1 from the next cycle.
- BUSY states:
  - m_* are stable and req changes are ignored.
  - On m_ack, deassert the strobe on the next edge and return to IDLE.
  - Register the completion: ready=1 for exactly one cycle.
  - rdata <= m_rdata for reads; d_rdata is unchanged on writes.
- Latency: grant cycle + busy cycle(s) until m_ack + ready cycle. With a same-cycle ack the minimum is 3 cycles.
- Back-to-back:
  - IDLE is re-entered in the ready cycle.
  - The other side, if eligible, is granted in that same cycle.
  - There are no idle bubbles beyond the ready cycle.
- Requester drops req mid-transaction (I-side flush on a taken branch):
  - The transaction still completes on the memory side.
  - No ready pulse; rdata is not updated.
- Simultaneous i_req and d_req in IDLE: D is granted and I stalls (i_stall=1) until served.
- Reset mid-transaction:
  - The transaction is abandoned and strobes drop immediately.
  - The memory model must tolerate a strobe withdrawn without ack.
- m_ack while IDLE: ignored.
- m_read and m_write are never high together.

Optional Feature:
ARB_ROUND_ROBIN_EN
- Defined: a last_grant flop is updated at each grant. When both sides are eligible in IDLE, the side not granted last wins.
- Undefined: fixed D-over-I priority and last_grant is absent.
- All other behaviour is identical in both builds.

Decomposition:
- State encodings (IDLE=2'd0, I_BUSY=2'd1, D_BUSY=2'd2) go as `define constants in a shared header next to opcodes.v, so pipeline control and benches can decode them.
- WORD_SIZE comes from opcodes.v.
- Single module; no sub-module is natural, since the FSM and latches are tightly coupled.

Test Plan:
- Reset then idle: hold reset_n=0 with i_req=1 -> all outputs 0. After release with no reqs -> m_read=m_write=0 indefinitely.
- Single fetch: i_req=1, i_addr=16'h0010; memory acks 2 cycles after m_read with m_rdata=16'h6A01 -> m_addr=16'h0010, then i_ready pulses one cycle with i_rdata=16'h6A01, and i_stall=1 until then.
- Conflict: i_req and d_req (read, d_addr=16'h0040) rise in the same cycle -> D is served first with d_rdata=m_rdata. I is granted in D's ready cycle, and i_stall=1 throughout.
- Store: d_we=1, d_addr=16'h0041, d_wdata=16'hBEEF -> m_write=1 with m_wdata=16'hBEEF; d_ready pulses and d_rdata is unchanged.
- Flush: i_req is dropped during I_BUSY -> after ack there is no i_ready and i_rdata keeps its old value.
- Reset mid-op: reset_n=0 during D_BUSY -> strobes drop asynchronously, state=IDLE, and no d_ready after release.
- With ARB_ROUND_ROBIN_EN: both sides requesting continuously -> grants alternate D, I, D, I.
